// File: rtl/mac_col_sequencer_vert_pkg.sv
// Shared types and helpers for the vertical bit-column MAC sequencer.
//   col_state_t : sequencer FSM states (IDLE -> RUN -> DONE)
//   acc_width() : exact dot-product accumulator width for a given data width and vector length
//   popcount()  : number of set bits in a vector of up to POPCOUNT_MAX bits
package bitsim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } col_state_t;

  localparam int POPCOUNT_MAX = 32;

  // Product of two DATA_WIDTH signed values needs 2*DATA_WIDTH bits, and summing
  // VEC_LENGTH of them adds $clog2(VEC_LENGTH) bits of growth.
  function automatic int acc_width(input int data_width, input int vec_length);
    return 2 * data_width + $clog2(vec_length);
  endfunction

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCOUNT_MAX; i++) begin
      if (bits[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_col_sequencer_vert_if.sv
// Bus between the sequencer, its upstream buffers, the column MAC and the psum writer.
//   in_*   : vector input handshake (weights, activations, precomputed sum of activations)
//   mac_*  : per-column drive to the combinational MAC and its same-cycle result
//   out_*  : dot-product output handshake
// Modports: slave = the sequencer, master = everything around it.
interface mac_col_sequencer_vert_if
  import bitsim_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 4,
  parameter int SUM_ACT_WIDTH = 11,
  parameter int ACC_WIDTH     = acc_width(DATA_WIDTH, VEC_LENGTH)
);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_weight;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  in_act;
  logic [SUM_ACT_WIDTH-1:0]               in_sum_act;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  mac_adder_in;
  logic [SUM_ACT_WIDTH-1:0]               mac_sum_act;
  logic                                   mac_is_msb;
  logic                                   mac_is_skip_zero;
  logic [SUM_ACT_WIDTH-1:0]               mac_result;

  logic                                   out_valid;
  logic                                   out_ready;
  logic [ACC_WIDTH-1:0]                   out_data;

  modport slave (
    input  in_valid, in_weight, in_act, in_sum_act, mac_result, out_ready,
    output in_ready, mac_adder_in, mac_sum_act, mac_is_msb, mac_is_skip_zero,
           out_valid, out_data
  );

  modport master (
    output in_valid, in_weight, in_act, in_sum_act, mac_result, out_ready,
    input  in_ready, mac_adder_in, mac_sum_act, mac_is_msb, mac_is_skip_zero,
           out_valid, out_data
  );

endinterface

// File: rtl/mac_col_sequencer_vert_gate.sv
// mac_col_gate: combinational per-column logic.
//   enable       : high only while the sequencer is streaming columns
//   col          : bit index of the current weight column
//   weight, act  : latched weight and activation vectors
//   adder_in     : activations gated onto the MAC adder tree
//   is_skip_zero : 1 -> adder sums acts whose weight bit is 1; 0 -> acts whose bit is 0
// Picking the encoding with the fewer passed activations keeps at most VEC_LENGTH/2
// operands active; the MAC recovers the other case from sum_act.
module mac_col_gate
  import bitsim_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 4,
  parameter int COL_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                                  enable,
  input  logic [COL_WIDTH-1:0]                  col,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] adder_in,
  output logic                                  is_skip_zero
);

  logic [VEC_LENGTH-1:0] col_bits;
  logic                  skip_zero;

  // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
  always_comb begin
    col_bits = '0;
    adder_in = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      col_bits[i] = weight[i][col];
    end
    // Ties (exactly half ones) and all-zero columns resolve to skip-zero.
    skip_zero = int'(popcount(POPCOUNT_MAX'(col_bits))) <= VEC_LENGTH / 2;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      if (enable && (col_bits[i] == skip_zero)) adder_in[i] = act[i];
    end
    is_skip_zero = enable && skip_zero;
  end

endmodule

// File: rtl/mac_col_sequencer_vert.sv
// mac_col_sequencer_vert: drives the combinational vertical bit-column MAC.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mac_col_sequencer_vert_if.slave (in_*, mac_*, out_* groups)
// Latches one vector, streams weight bit-columns MSB->LSB one per cycle, and
// shift-accumulates the signed column results into the full dot product.
// mac_* outputs depend only on latched registers, col and state, never on in_*.
module mac_col_sequencer_vert
  import bitsim_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 4,
  parameter int SUM_ACT_WIDTH = 11,
  parameter int ACC_WIDTH     = acc_width(DATA_WIDTH, VEC_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac_col_sequencer_vert_if.slave bus
);

  localparam int                   COL_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [COL_WIDTH-1:0] COL_MSB   = COL_WIDTH'(DATA_WIDTH - 1);

  col_state_t                            state;
  logic [COL_WIDTH-1:0]                  col;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
  logic [SUM_ACT_WIDTH-1:0]              sum_act_q;
  logic signed [ACC_WIDTH-1:0]           acc_q;
  logic signed [ACC_WIDTH-1:0]           acc_next;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic [ACC_WIDTH-1:0]                  out_data_q;
  logic                                  run;

  assign run = (state == RUN);

  // Earlier columns carry twice the weight of the next one, so shift before adding.
  assign acc_next = (acc_q <<< 1)
                  + {{(ACC_WIDTH - SUM_ACT_WIDTH){bus.mac_result[SUM_ACT_WIDTH-1]}},
                     bus.mac_result};

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      weight_q    <= '0;
      act_q       <= '0;
      sum_act_q   <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            weight_q   <= bus.in_weight;
            act_q      <= bus.in_act;
            sum_act_q  <= bus.in_sum_act;
            col        <= COL_MSB;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (col == '0) begin
            out_data_q  <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            col <= col - COL_WIDTH'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_col_gate #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH),
    .COL_WIDTH  (COL_WIDTH)
  ) u_gate (
    .enable       (run),
    .col          (col),
    .weight       (weight_q),
    .act          (act_q),
    .adder_in     (bus.mac_adder_in),
    .is_skip_zero (bus.mac_is_skip_zero)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.mac_is_msb  = run && (col == COL_MSB);
  assign bus.mac_sum_act = run ? sum_act_q : '0;

endmodule

// File: tb/tb_mac_col_sequencer_vert.sv
// Testbench for mac_col_sequencer_vert together with a behavioural column MAC.
// Expected dot products come from plain integer arithmetic on the input vectors.
module tb_mac_col_sequencer_vert;

  localparam int DW = 8;
  localparam int VL = 4;
  localparam int SW = 11;
  localparam int AW = 2 * DW + $clog2(VL);

  typedef logic [VL-1:0][DW-1:0] vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mac_col_sequencer_vert_if #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SUM_ACT_WIDTH(SW), .ACC_WIDTH(AW)
  ) bus ();

  mac_col_sequencer_vert #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .SUM_ACT_WIDTH(SW), .ACC_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column MAC: sum of the gated activations, complemented against sum_act for
  // skip-one columns, negated on the two's-complement sign column.
  int mac_sel_sum;
  int mac_col_val;
  always_comb begin
    mac_sel_sum = 0;
    for (int i = 0; i < VL; i++) mac_sel_sum += int'($signed(bus.mac_adder_in[i]));
    mac_col_val = bus.mac_is_skip_zero ? mac_sel_sum
                                       : int'($signed(bus.mac_sum_act)) - mac_sel_sum;
    if (bus.mac_is_msb) mac_col_val = -mac_col_val;
    bus.mac_result = SW'(mac_col_val);
  end

  function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3);
    vec_t v;
    v[0] = DW'(x0);
    v[1] = DW'(x1);
    v[2] = DW'(x2);
    v[3] = DW'(x3);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VL; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  function automatic int dot(input vec_t w, input vec_t a);
    int s;
    s = 0;
    for (int i = 0; i < VL; i++) s += int'($signed(w[i])) * int'($signed(a[i]));
    return s;
  endfunction

  function automatic int vec_sum(input vec_t a);
    int s;
    s = 0;
    for (int i = 0; i < VL; i++) s += int'($signed(a[i]));
    return s;
  endfunction

  // Drives one vector from IDLE, checks each column's drive, then the result and handshake.
  // With stall > 0, out_ready is held low that many cycles in DONE and in_valid is
  // pulsed with garbage during RUN and DONE to confirm it is ignored.
  task automatic run_vector(input vec_t w, input vec_t a, input int stall, input string name);
    int   exp_dot;
    int   ones;
    int   waited;
    logic exp_skip;
    vec_t exp_adder;
    exp_dot = dot(w, a);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", name, bus.in_ready);
    end
    bus.in_weight  = w;
    bus.in_act     = a;
    bus.in_sum_act = SW'(vec_sum(a));
    bus.in_valid   = 1'b1;
    bus.out_ready  = (stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = DW - 1; c >= 0; c--) begin
      ones = 0;
      for (int i = 0; i < VL; i++) if (w[i][c]) ones++;
      exp_skip = (ones <= VL / 2);
      for (int i = 0; i < VL; i++) begin
        if (exp_skip) exp_adder[i] = w[i][c] ? a[i] : '0;
        else          exp_adder[i] = w[i][c] ? '0 : a[i];
      end
      checks++;
      if ({bus.mac_is_msb, bus.mac_is_skip_zero, bus.in_ready} !== {c == DW - 1, exp_skip, 1'b0}) begin
        errors++;
        $display("FAIL %s col%0d msb/skip/ready: got %b%b%b want %b%b0", name, c,
                 bus.mac_is_msb, bus.mac_is_skip_zero, bus.in_ready, c == DW - 1, exp_skip);
      end
      checks++;
      if (bus.mac_adder_in !== exp_adder || bus.mac_sum_act !== SW'(vec_sum(a))) begin
        errors++;
        $display("FAIL %s col%0d adder_in: got %h/%h want %h/%h", name, c,
                 bus.mac_adder_in, bus.mac_sum_act, exp_adder, SW'(vec_sum(a)));
      end
      if (stall > 0) begin
        bus.in_valid   = 1'b1;
        bus.in_weight  = rand_vec();
        bus.in_act     = rand_vec();
        bus.in_sum_act = SW'($urandom);
      end
      @(negedge clk);
    end
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    // Result must be visible within DATA_WIDTH+1 cycles of the accept edge.
    checks++;
    if (bus.out_valid !== 1'b1 || waited > 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles valid=%b want <=%0d", name, DW + waited,
               bus.out_valid, DW + 1);
    end
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== AW'(exp_dot) || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d: got valid=%b data=%0d ready=%b want 1 %0d 0", name, s,
                 bus.out_valid, $signed(bus.out_data), bus.in_ready, exp_dot);
      end
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_data !== AW'(exp_dot)) begin
      errors++;
      $display("FAIL %s out_data: got %0d want %0d", name, $signed(bus.out_data), exp_dot);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_handshake: got valid=%b ready=%b want 0 1", name,
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL %s handshake: got ready=%b valid=%b data=%h want 1 0 0", name,
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.mac_adder_in !== '0 || bus.mac_sum_act !== '0 ||
        bus.mac_is_msb !== 1'b0 || bus.mac_is_skip_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s mac_outputs: got %h %h %b %b want all 0", name, bus.mac_adder_in,
               bus.mac_sum_act, bus.mac_is_msb, bus.mac_is_skip_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_directed();
    run_vector(mk(1, 1, 1, 1), mk(1, 2, 3, 4), 0, "ones_x_ramp");
    run_vector(mk(-128, -128, -128, -128), mk(127, 127, 127, 127), 0, "neg_max_x_pos_max");
    run_vector(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128), 0, "neg_max_x_neg_max");
    run_vector(mk(0, 0, 0, 0), mk(55, -3, 9, -77), 0, "zero_weights");
  endtask

  task automatic test_stall();
    run_vector(mk(3, -1, 0, -128), mk(-5, 7, 100, 1), 5, "stall_mixed");
  endtask

  task automatic test_reset_mid_run();
    bus.in_weight  = rand_vec();
    bus.in_act     = rand_vec();
    bus.in_sum_act = SW'(vec_sum(bus.in_act));
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    // Now streaming column 4.
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vector(mk(2, 2, 2, 2), mk(1, 1, 1, 1), 0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_vector(rand_vec(), rand_vec(), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end
  endtask

  // in_valid held high with out_ready high: accepts must be DATA_WIDTH+2 cycles apart.
  task automatic test_back_to_back();
    vec_t w;
    vec_t a;
    int   accepts[$];
    int   results;
    w = rand_vec();
    a = rand_vec();
    results = 0;
    bus.in_weight  = w;
    bus.in_act     = a;
    bus.in_sum_act = SW'(vec_sum(a));
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 3 * (DW + 2) + 2; k++) begin
      if (bus.in_ready === 1'b1) accepts.push_back(k);
      if (bus.out_valid === 1'b1) begin
        results++;
        checks++;
        if (bus.out_data !== AW'(dot(w, a))) begin
          errors++;
          $display("FAIL b2b out_data: got %0d want %0d", $signed(bus.out_data), dot(w, a));
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepts.size() < 3 || results < 2) begin
      errors++;
      $display("FAIL b2b counts: got %0d accepts %0d results want >=3 >=2",
               accepts.size(), results);
    end else begin
      for (int j = 1; j < accepts.size(); j++) begin
        checks++;
        if (accepts[j] - accepts[j-1] != DW + 2) begin
          errors++;
          $display("FAIL b2b spacing: got %0d cycles want %0d", accepts[j] - accepts[j-1], DW + 2);
        end
      end
    end
    // Drain the vector still in flight.
    for (int k = 0; k < DW + 4 && bus.in_ready !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_weight  = '0;
    bus.in_act     = '0;
    bus.in_sum_act = '0;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
